trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Machine-mode trap and return sequencer between the pipeline and the M-mode CSR file. It samples exception flags, pending interrupts and `mret` once per retiring instruction, then chooses the winning event by RISC-V priority. It issues the one-cycle CSR update strobe (trap or return) and stalls and flushes the pipeline for the sequence. It then redirects the PC to `mtvec` (direct or vectored) or to `mepc`.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `VECTORED_EN`, 1: honour `mtvec[1:0]==2'b01` vectored mode for interrupts; 0 forces direct mode.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous active-high reset.
- `inst_valid`  in  1  an instruction is at the commit boundary this cycle.
- `inst_pc`  in  XLEN  PC of that instruction.
- `inst_word`  in  32  raw encoding, used as tval for illegal instructions.
- `mem_addr`  in  XLEN  effective address, used as tval for load/store misalignment.
- `exc_if_misalign`, `exc_illegal`, `exc_ebreak`, `exc_ecall`, `exc_ld_misalign`, `exc_st_misalign`  in  1 each  exception flags, qualified by `inst_valid`.
- `is_mret`  in  1  the instruction is `mret`.
- `priv_mode`  in  2  current privilege: 2'b00 U, 2'b11 M.
- `mstatus_mie`  in  1  global interrupt enable.
- `mie`, `mip`  in  XLEN  interrupt enable and pending; bits 3 MSI, 7 MTI, 11 MEI are used.
- `mtvec`, `mepc`  in  XLEN  CSR values.
- `csr_trap`  out  1  one-cycle strobe telling the CSR file to latch the trap.
- `csr_mret`  out  1  one-cycle strobe telling the CSR file to perform return.
- `trap_cause`  out  4  exception or interrupt code.
- `trap_irq`  out  1  cause is an interrupt (mcause bit XLEN-1).
- `trap_epc`, `trap_tval`  out  XLEN  values to write into mepc and mtval.
- `stall`  out  1  freeze fetch/decode.
- `flush`  out  1  kill in-flight instructions.
- `redirect_valid`  out  1  load `redirect_pc` into the PC.
- `redirect_pc`  out  XLEN  new PC.

## Operation
- FSM states:
  - IDLE.
  - TRAP: `csr_trap`=1, `stall`=1, `flush`=1.
  - RET: `csr_mret`=1, `stall`=1, `flush`=1.
  - REDIR: `redirect_valid`=1, `stall`=1, `flush`=1.
- State transitions:
  - IDLE to TRAP when `inst_valid` and a trap wins.
  - IDLE to RET when `inst_valid` and `is_mret` and no trap.
  - TRAP to REDIR and RET to REDIR unconditionally.
  - REDIR to IDLE.
  - Inputs are ignored outside IDLE.
- Interrupt take condition: `(mie & mip)` has a bit among 3/7/11 set, and (`priv_mode`==U or `mstatus_mie`).
  - Priority MEI(11) > MSI(3) > MTI(7).
- A taken interrupt beats any exception flags and `is_mret` of the same instruction. That instruction does not execute.
- Exception priority, highest first:
  - ebreak(3), if_misalign(0), illegal(2), ecall, ld_misalign(4), st_misalign(6).
  - ecall cause is 8 from U and 11 from M.
- Trap beats `is_mret`. An `mret` flagged illegal takes the illegal trap.
- Captured on the IDLE exit edge and held stable through REDIR:
  - `trap_epc` = `inst_pc`.
  - `trap_tval`:
    - `inst_word` for illegal.
    - `mem_addr` for ld/st misalign.
    - `inst_pc` for if_misalign and ebreak.
    - 0 otherwise.
- Redirect target:
  - After RET: `mepc` sampled in RET.
  - After TRAP: `{mtvec[XLEN-1:2],2'b00}`, plus `4*trap_cause` when `trap_irq` and vectored mode are active. Arithmetic is modulo 2^XLEN.
  - `mtvec` is sampled in TRAP, after the CSR write.
- Reset values:
  - State IDLE.
  - All strobes, `stall`, `flush`, `redirect_valid` at 0.
  - `trap_cause`, `trap_irq`, `trap_epc`, `trap_tval`, `redirect_pc` at 0.

## Timing
- Event sampled at cycle N.
- Cycle N+1: strobe (`csr_trap` or `csr_mret`) is high; the CSR file updates on it.
- Cycle N+2: `redirect_valid` is high.
- Cycle N+3: back in IDLE; the first instruction at the target may be sampled.
- `stall` and `flush` are high exactly in N+1 and N+2.
- Each strobe lasts exactly one cycle per event. Back-to-back events need at least 3 cycles.
- `reset` asserted mid-sequence: next cycle is IDLE with all outputs at reset value; no partial strobe or redirect.
- An interrupt that becomes pending during TRAP/RET/REDIR is evaluated at the first IDLE cycle, against the updated `mstatus_mie`.

## Structure
- Package `trap_pkg`:
  - cause codes (`CAUSE_IF_MISALIGN`=0 … `CAUSE_ECALL_M`=11, `IRQ_MSI`=3, `IRQ_MTI`=7, `IRQ_MEI`=11);
  - FSM state enum;
  - privilege constants U=2'b00, M=2'b11.
- Sub-module `trap_prio_enc` is combinational. It takes the flags, masked interrupts and `priv_mode`. It returns take, is_irq, cause and tval_sel.
- The FSM and capture registers live in `trap_sequencer`.

## Test plan
- Illegal at `inst_pc`=0x100, `inst_word`=0xFFFFFFFF, `mtvec`=0x200. Expect `csr_trap` at N+1 with cause 2, `trap_irq`=0, epc 0x100, tval 0xFFFFFFFF. Expect redirect to 0x200 at N+2.
- ecall from U, then from M. Expect cause 8, then cause 11. Simultaneous ecall+ld_misalign gives cause 8.
- MTI and MEI both pending with `mie`=0x888, `mstatus_mie`=1, M-mode, `mtvec`=0x301, illegal flag also set. Expect cause 11, `trap_irq`=1, redirect 0x300+44=0x32C.
- `mstatus_mie`=0 in M-mode with MTI pending: no trap. Same in U-mode: trap taken.
- `mret` with `mepc`=0x80: `csr_mret` at N+1, redirect 0x80 at N+2, never a `csr_trap`. `mret`+illegal gives only a trap with cause 2.
- `reset` raised in TRAP state: next cycle all outputs 0, IDLE. The following exception is sequenced normally.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared cause codes, privilege encodings and state types for the M-mode trap sequencer.
package trap_pkg;

    localparam int unsigned CAUSE_W = 4;

    localparam logic [CAUSE_W-1:0] CAUSE_IF_MISALIGN = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT  = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL_U     = 4'd8;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M     = 4'd11;

    localparam logic [CAUSE_W-1:0] IRQ_MSI = 4'd3;
    localparam logic [CAUSE_W-1:0] IRQ_MTI = 4'd7;
    localparam logic [CAUSE_W-1:0] IRQ_MEI = 4'd11;

    // Bit positions of the interrupt sources inside mie/mip
    localparam int unsigned IRQ_MSI_BIT = 3;
    localparam int unsigned IRQ_MTI_BIT = 7;
    localparam int unsigned IRQ_MEI_BIT = 11;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_RET,
        ST_REDIR
    } state_e;

    typedef enum logic [1:0] {
        TVAL_ZERO,
        TVAL_INST,
        TVAL_ADDR,
        TVAL_PC
    } tval_sel_e;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational trap arbiter: picks the winning interrupt or exception by RISC-V priority.
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic               exc_if_misalign,
    input  logic               exc_illegal,
    input  logic               exc_ebreak,
    input  logic               exc_ecall,
    input  logic               exc_ld_misalign,
    input  logic               exc_st_misalign,
    input  logic               irq_msi,
    input  logic               irq_mti,
    input  logic               irq_mei,
    input  logic [1:0]         priv_mode,
    output logic               take_c,
    output logic               is_irq_c,
    output logic [CAUSE_W-1:0] cause_c,
    output tval_sel_e          tval_sel_c
);

    // Interrupts (already enable-qualified) outrank every synchronous exception
    always_comb begin
        take_c     = 1'b1;
        is_irq_c   = 1'b0;
        cause_c    = '0;
        tval_sel_c = TVAL_ZERO;
        if (irq_mei) begin
            is_irq_c = 1'b1;
            cause_c  = IRQ_MEI;
        end else if (irq_msi) begin
            is_irq_c = 1'b1;
            cause_c  = IRQ_MSI;
        end else if (irq_mti) begin
            is_irq_c = 1'b1;
            cause_c  = IRQ_MTI;
        end else if (exc_ebreak) begin
            cause_c    = CAUSE_BREAKPOINT;
            tval_sel_c = TVAL_PC;
        end else if (exc_if_misalign) begin
            cause_c    = CAUSE_IF_MISALIGN;
            tval_sel_c = TVAL_PC;
        end else if (exc_illegal) begin
            cause_c    = CAUSE_ILLEGAL;
            tval_sel_c = TVAL_INST;
        end else if (exc_ecall) begin
            cause_c = (priv_mode == PRIV_U) ? CAUSE_ECALL_U : CAUSE_ECALL_M;
        end else if (exc_ld_misalign) begin
            cause_c    = CAUSE_LD_MISALIGN;
            tval_sel_c = TVAL_ADDR;
        end else if (exc_st_misalign) begin
            cause_c    = CAUSE_ST_MISALIGN;
            tval_sel_c = TVAL_ADDR;
        end else begin
            take_c = 1'b0;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// M-mode trap/mret sequencer: arbitrates the committing instruction, strobes the CSR file,
// then stalls/flushes and redirects the PC to mtvec or mepc.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_valid,
    input  logic [XLEN-1:0]    inst_pc,
    input  logic [31:0]        inst_word,
    input  logic [XLEN-1:0]    mem_addr,
    input  logic               exc_if_misalign,
    input  logic               exc_illegal,
    input  logic               exc_ebreak,
    input  logic               exc_ecall,
    input  logic               exc_ld_misalign,
    input  logic               exc_st_misalign,
    input  logic               is_mret,
    input  logic [1:0]         priv_mode,
    input  logic               mstatus_mie,
    input  logic [XLEN-1:0]    mie,
    input  logic [XLEN-1:0]    mip,
    input  logic [XLEN-1:0]    mtvec,
    input  logic [XLEN-1:0]    mepc,
    output logic               csr_trap,
    output logic               csr_mret,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic               trap_irq,
    output logic [XLEN-1:0]    trap_epc,
    output logic [XLEN-1:0]    trap_tval,
    output logic               stall,
    output logic               flush,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc
);

    state_e             state_q, state_d;
    logic               csr_trap_q, csr_trap_d;
    logic               csr_mret_q, csr_mret_d;
    logic               stall_q, stall_d;
    logic               flush_q, flush_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [CAUSE_W-1:0] trap_cause_q, trap_cause_d;
    logic               trap_irq_q, trap_irq_d;
    logic [XLEN-1:0]    trap_epc_q, trap_epc_d;
    logic [XLEN-1:0]    trap_tval_q, trap_tval_d;
    logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;

    logic [XLEN-1:0]    irq_pend;
    logic               irq_en;
    logic               pend_unused;
    logic               take;
    logic               is_irq;
    logic [CAUSE_W-1:0] cause;
    tval_sel_e          tval_sel;
    logic [XLEN-1:0]    tval_mux;
    logic [XLEN-1:0]    trap_target;

    // Interrupts are always enabled below M; in M they need mstatus.MIE
    assign irq_pend    = mie & mip;
    assign irq_en      = (priv_mode == PRIV_U) || mstatus_mie;
    assign pend_unused = ^{irq_pend[XLEN-1:12], irq_pend[10:8], irq_pend[6:4], irq_pend[2:0]};

    trap_prio_enc u_prio_enc (
        .exc_if_misalign (exc_if_misalign),
        .exc_illegal     (exc_illegal),
        .exc_ebreak      (exc_ebreak),
        .exc_ecall       (exc_ecall),
        .exc_ld_misalign (exc_ld_misalign),
        .exc_st_misalign (exc_st_misalign),
        .irq_msi         (irq_en & irq_pend[IRQ_MSI_BIT]),
        .irq_mti         (irq_en & irq_pend[IRQ_MTI_BIT]),
        .irq_mei         (irq_en & irq_pend[IRQ_MEI_BIT]),
        .priv_mode       (priv_mode),
        .take_c          (take),
        .is_irq_c        (is_irq),
        .cause_c         (cause),
        .tval_sel_c      (tval_sel)
    );

    always_comb begin
        tval_mux = '0;
        case (tval_sel)
            TVAL_INST: tval_mux = XLEN'(inst_word);
            TVAL_ADDR: tval_mux = mem_addr;
            TVAL_PC:   tval_mux = inst_pc;
            default:   tval_mux = '0;
        endcase
    end

    // mtvec is read in TRAP, so a same-cycle CSR write to it is already visible
    always_comb begin
        trap_target = {mtvec[XLEN-1:2], 2'b00};
        if (VECTORED_EN && trap_irq_q && (mtvec[1:0] == 2'b01)) begin
            trap_target = trap_target + XLEN'({trap_cause_q, 2'b00});
        end
    end

    always_comb begin
        state_d       = state_q;
        trap_cause_d  = trap_cause_q;
        trap_irq_d    = trap_irq_q;
        trap_epc_d    = trap_epc_q;
        trap_tval_d   = trap_tval_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (inst_valid && take) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = cause;
                    trap_irq_d   = is_irq;
                    trap_epc_d   = inst_pc;
                    trap_tval_d  = tval_mux;
                end else if (inst_valid && is_mret) begin
                    state_d = ST_RET;
                end
            end
            ST_TRAP: begin
                state_d       = ST_REDIR;
                redirect_pc_d = trap_target;
            end
            ST_RET: begin
                state_d       = ST_REDIR;
                redirect_pc_d = mepc;
            end
            ST_REDIR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Outputs registered from the next state so they align with the state they describe
        csr_trap_d       = (state_d == ST_TRAP);
        csr_mret_d       = (state_d == ST_RET);
        redirect_valid_d = (state_d == ST_REDIR);
        stall_d          = (state_d != ST_IDLE);
        flush_d          = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            csr_trap_q       <= 1'b0;
            csr_mret_q       <= 1'b0;
            stall_q          <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            trap_cause_q     <= '0;
            trap_irq_q       <= 1'b0;
            trap_epc_q       <= '0;
            trap_tval_q      <= '0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            csr_trap_q       <= csr_trap_d;
            csr_mret_q       <= csr_mret_d;
            stall_q          <= stall_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            trap_cause_q     <= trap_cause_d;
            trap_irq_q       <= trap_irq_d;
            trap_epc_q       <= trap_epc_d;
            trap_tval_q      <= trap_tval_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign csr_trap       = csr_trap_q;
    assign csr_mret       = csr_mret_q;
    assign stall          = stall_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign trap_cause     = trap_cause_q;
    assign trap_irq       = trap_irq_q;
    assign trap_epc       = trap_epc_q;
    assign trap_tval      = trap_tval_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: hand-computed trap/mret sequences checked cycle by cycle.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [31:0] inst_pc, inst_word, mem_addr;
    logic        exc_if_misalign, exc_illegal, exc_ebreak, exc_ecall, exc_ld_misalign, exc_st_misalign;
    logic        is_mret;
    logic [1:0]  priv_mode;
    logic        mstatus_mie;
    logic [31:0] mie, mip, mtvec, mepc;
    logic        csr_trap, csr_mret, trap_irq, stall, flush, redirect_valid;
    logic [3:0]  trap_cause;
    logic [31:0] trap_epc, trap_tval, redirect_pc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    trap_sequencer #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_valid      (inst_valid),
        .inst_pc         (inst_pc),
        .inst_word       (inst_word),
        .mem_addr        (mem_addr),
        .exc_if_misalign (exc_if_misalign),
        .exc_illegal     (exc_illegal),
        .exc_ebreak      (exc_ebreak),
        .exc_ecall       (exc_ecall),
        .exc_ld_misalign (exc_ld_misalign),
        .exc_st_misalign (exc_st_misalign),
        .is_mret         (is_mret),
        .priv_mode       (priv_mode),
        .mstatus_mie     (mstatus_mie),
        .mie             (mie),
        .mip             (mip),
        .mtvec           (mtvec),
        .mepc            (mepc),
        .csr_trap        (csr_trap),
        .csr_mret        (csr_mret),
        .trap_cause      (trap_cause),
        .trap_irq        (trap_irq),
        .trap_epc        (trap_epc),
        .trap_tval       (trap_tval),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_inst();
        inst_valid      = 1'b0;
        exc_if_misalign = 1'b0;
        exc_illegal     = 1'b0;
        exc_ebreak      = 1'b0;
        exc_ecall       = 1'b0;
        exc_ld_misalign = 1'b0;
        exc_st_misalign = 1'b0;
        is_mret         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ".trap"},  32'(csr_trap), 32'd0);
        chk({tag, ".mret"},  32'(csr_mret), 32'd0);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        chk({tag, ".flush"}, 32'(flush), 32'd0);
        chk({tag, ".rv"},    32'(redirect_valid), 32'd0);
    endtask

    // Inputs must be set up before the call; the task samples at N, checks N+1..N+3
    task automatic run_seq(input string tag, input logic is_trap, input logic [3:0] cause,
                           input logic irq, input logic [31:0] epc, input logic [31:0] tval,
                           input logic [31:0] tgt);
        tick();
        clear_inst();
        chk({tag, ".n1.trap"},  32'(csr_trap), 32'(is_trap));
        chk({tag, ".n1.mret"},  32'(csr_mret), 32'(!is_trap));
        chk({tag, ".n1.stall"}, 32'(stall), 32'd1);
        chk({tag, ".n1.flush"}, 32'(flush), 32'd1);
        chk({tag, ".n1.rv"},    32'(redirect_valid), 32'd0);
        if (is_trap) begin
            chk({tag, ".cause"}, 32'(trap_cause), 32'(cause));
            chk({tag, ".irq"},   32'(trap_irq), 32'(irq));
            chk({tag, ".epc"},   trap_epc, epc);
            chk({tag, ".tval"},  trap_tval, tval);
        end
        tick();
        chk({tag, ".n2.trap"},  32'(csr_trap), 32'd0);
        chk({tag, ".n2.mret"},  32'(csr_mret), 32'd0);
        chk({tag, ".n2.rv"},    32'(redirect_valid), 32'd1);
        chk({tag, ".n2.pc"},    redirect_pc, tgt);
        chk({tag, ".n2.stall"}, 32'(stall), 32'd1);
        chk({tag, ".n2.flush"}, 32'(flush), 32'd1);
        if (is_trap) chk({tag, ".n2.cause"}, 32'(trap_cause), 32'(cause));
        tick();
        check_quiet({tag, ".n3"});
    endtask

    initial begin
        reset = 1'b1;
        clear_inst();
        inst_pc = '0; inst_word = '0; mem_addr = '0;
        priv_mode = 2'b11; mstatus_mie = 1'b0;
        mie = '0; mip = '0; mtvec = 32'h200; mepc = '0;
        tick();
        tick();
        reset = 1'b0;
        check_quiet("rst");
        chk("rst.cause", 32'(trap_cause), 32'd0);
        chk("rst.epc",   trap_epc, 32'd0);
        chk("rst.tval",  trap_tval, 32'd0);
        chk("rst.rpc",   redirect_pc, 32'd0);

        // Illegal instruction
        inst_valid = 1'b1; exc_illegal = 1'b1; inst_pc = 32'h100; inst_word = 32'hFFFF_FFFF;
        run_seq("illegal", 1'b1, 4'd2, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h200);

        // ecall from U then M; ecall beats ld_misalign
        priv_mode = 2'b00; inst_valid = 1'b1; exc_ecall = 1'b1; inst_pc = 32'h104;
        run_seq("ecall_u", 1'b1, 4'd8, 1'b0, 32'h104, 32'h0, 32'h200);
        priv_mode = 2'b11; inst_valid = 1'b1; exc_ecall = 1'b1; inst_pc = 32'h108;
        run_seq("ecall_m", 1'b1, 4'd11, 1'b0, 32'h108, 32'h0, 32'h200);
        priv_mode = 2'b00; inst_valid = 1'b1; exc_ecall = 1'b1; exc_ld_misalign = 1'b1;
        inst_pc = 32'h10C; mem_addr = 32'h1234;
        run_seq("ecall_ld", 1'b1, 4'd8, 1'b0, 32'h10C, 32'h0, 32'h200);

        // Load and store misalign carry mem_addr as tval
        priv_mode = 2'b11; inst_valid = 1'b1; exc_ld_misalign = 1'b1; inst_pc = 32'h110; mem_addr = 32'h1002;
        run_seq("ld_mis", 1'b1, 4'd4, 1'b0, 32'h110, 32'h1002, 32'h200);
        inst_valid = 1'b1; exc_st_misalign = 1'b1; inst_pc = 32'h114; mem_addr = 32'h2001;
        run_seq("st_mis", 1'b1, 4'd6, 1'b0, 32'h114, 32'h2001, 32'h200);

        // ebreak beats if_misalign and illegal; if_misalign beats illegal
        inst_valid = 1'b1; exc_ebreak = 1'b1; exc_if_misalign = 1'b1; exc_illegal = 1'b1; inst_pc = 32'h118;
        run_seq("ebreak", 1'b1, 4'd3, 1'b0, 32'h118, 32'h118, 32'h200);
        inst_valid = 1'b1; exc_if_misalign = 1'b1; exc_illegal = 1'b1; inst_pc = 32'h11E;
        run_seq("if_mis", 1'b1, 4'd0, 1'b0, 32'h11E, 32'h11E, 32'h200);

        // MEI beats MTI and the illegal flag; vectored target 0x300 + 4*11
        mie = 32'h888; mip = 32'h880; mstatus_mie = 1'b1; mtvec = 32'h301;
        inst_valid = 1'b1; exc_illegal = 1'b1; inst_pc = 32'h400;
        run_seq("mei_vec", 1'b1, 4'd11, 1'b1, 32'h400, 32'h0, 32'h32C);
        mip = 32'h088;
        inst_valid = 1'b1; inst_pc = 32'h404;
        run_seq("msi_vec", 1'b1, 4'd3, 1'b1, 32'h404, 32'h0, 32'h30C);

        // MTI masked in M when MIE=0; taken from U regardless
        mip = 32'h080; mstatus_mie = 1'b0; priv_mode = 2'b11;
        inst_valid = 1'b1; inst_pc = 32'h408;
        tick();
        clear_inst();
        check_quiet("mti_masked");
        tick();
        priv_mode = 2'b00; inst_valid = 1'b1; inst_pc = 32'h40C;
        run_seq("mti_u", 1'b1, 4'd7, 1'b1, 32'h40C, 32'h0, 32'h31C);

        // Direct mode ignores the cause offset
        mtvec = 32'h300; mip = 32'h800; priv_mode = 2'b11; mstatus_mie = 1'b1;
        inst_valid = 1'b1; inst_pc = 32'h410;
        run_seq("mei_dir", 1'b1, 4'd11, 1'b1, 32'h410, 32'h0, 32'h300);

        // mret, then mret flagged illegal
        mip = '0; mie = '0; mtvec = 32'h200; mepc = 32'h80;
        inst_valid = 1'b1; is_mret = 1'b1; inst_pc = 32'h500;
        run_seq("mret", 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 32'h80);
        inst_valid = 1'b1; is_mret = 1'b1; exc_illegal = 1'b1; inst_pc = 32'h504; inst_word = 32'h3020_0073;
        run_seq("mret_ill", 1'b1, 4'd2, 1'b0, 32'h504, 32'h3020_0073, 32'h200);

        // Reset while in TRAP, then a normal exception
        inst_valid = 1'b1; exc_illegal = 1'b1; inst_pc = 32'h600;
        tick();
        clear_inst();
        chk("rst_mid.pre_trap", 32'(csr_trap), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_quiet("rst_mid");
        chk("rst_mid.cause", 32'(trap_cause), 32'd0);
        chk("rst_mid.epc",   trap_epc, 32'd0);
        chk("rst_mid.rpc",   redirect_pc, 32'd0);
        tick();
        check_quiet("rst_mid.idle");
        inst_valid = 1'b1; exc_ecall = 1'b1; inst_pc = 32'h700;
        run_seq("post_rst", 1'b1, 4'd11, 1'b0, 32'h700, 32'h0, 32'h200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
